// File: rtl/breath_pkg.sv
// Shared definitions for the multi-channel breathing-LED driver: mode encodings and a
// counter-width helper.
package breath_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ON     = 2'b01,
    MODE_BREATH = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  // Bits needed to hold 0..max_val (at least one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/breath_timebase.sv
// Shared timebase: 1 us prescaler, PWM step counter and breath position counter, plus the
// registered frame and breath-cycle pulses.
module breath_timebase
  import breath_pkg::*;
#(
  parameter int unsigned  CNT_1US_MAX  = 49,
  parameter int unsigned  CNT_STEP_MAX = 999,
  localparam int unsigned PERIOD       = 2 * (CNT_STEP_MAX + 1),
  localparam int unsigned StepW        = cnt_width(CNT_STEP_MAX),
  localparam int unsigned PosW         = cnt_width(PERIOD - 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  output logic [StepW-1:0] cnt_step_o,
  output logic [PosW-1:0]  pos_o,
  output logic             frame_end_o,
  output logic             frame_tick_o,
  output logic             cycle_done_o
);

  localparam int unsigned UsW = cnt_width(CNT_1US_MAX);

  logic [UsW-1:0]   cnt_us_q, cnt_us_d;
  logic [StepW-1:0] cnt_step_q, cnt_step_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic             frame_tick_q, frame_tick_d;
  logic             cycle_done_q, cycle_done_d;
  logic             us_tick, step_wrap, pos_wrap, frame_end;

  assign us_tick   = enable_i && (cnt_us_q == UsW'(CNT_1US_MAX));
  assign step_wrap = (cnt_step_q == StepW'(CNT_STEP_MAX));
  assign pos_wrap  = (pos_q == PosW'(PERIOD - 1));
  assign frame_end = us_tick && step_wrap;

  always_comb begin
    cnt_us_d     = cnt_us_q;
    cnt_step_d   = cnt_step_q;
    pos_d        = pos_q;
    frame_tick_d = frame_end;
    cycle_done_d = frame_end && pos_wrap;
    if (!enable_i) begin
      cnt_us_d   = '0;
      cnt_step_d = '0;
      pos_d      = '0;
    end else begin
      cnt_us_d = us_tick ? '0 : cnt_us_q + 1'b1;
      if (us_tick) cnt_step_d = step_wrap ? '0 : cnt_step_q + 1'b1;
      if (frame_end) pos_d = pos_wrap ? '0 : pos_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_us_q     <= '0;
      cnt_step_q   <= '0;
      pos_q        <= '0;
      frame_tick_q <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      cnt_us_q     <= cnt_us_d;
      cnt_step_q   <= cnt_step_d;
      pos_q        <= pos_d;
      frame_tick_q <= frame_tick_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign cnt_step_o   = cnt_step_q;
  assign pos_o        = pos_q;
  assign frame_end_o  = frame_end;
  assign frame_tick_o = frame_tick_q;
  assign cycle_done_o = cycle_done_q;

endmodule

// File: rtl/breath_led_multi.sv
// Multi-channel breathing-LED driver: one shared timebase, per-channel phase-staggered
// level, frame-synchronised mode shadow and registered PWM pin drive.
module breath_led_multi
  import breath_pkg::*;
#(
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned CNT_1US_MAX  = 49,
  parameter int unsigned CNT_STEP_MAX = 999,
  parameter logic        LED_ON_LVL   = 1'b0,
  parameter bit          PHASE_EN     = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                enable,
  input  logic [2*CH_NUM-1:0] mode,
  output logic [CH_NUM-1:0]   led_out,
  output logic                frame_tick,
  output logic                cycle_done
);

  localparam int unsigned PERIOD = 2 * (CNT_STEP_MAX + 1);
  localparam int unsigned OFFSET = PHASE_EN ? PERIOD / CH_NUM : 0;
  localparam int unsigned StepW  = cnt_width(CNT_STEP_MAX);
  localparam int unsigned PosW   = cnt_width(PERIOD - 1);
  // Wide enough that pos + k*OFFSET cannot overflow before the wrap subtract.
  localparam int unsigned AddW   = cnt_width(2 * PERIOD - 1);

  logic [StepW-1:0] cnt_step;
  logic [PosW-1:0]  pos;
  logic             frame_end;

  breath_timebase #(
    .CNT_1US_MAX  (CNT_1US_MAX),
    .CNT_STEP_MAX (CNT_STEP_MAX)
  ) u_timebase (
    .clk_i        (sys_clk),
    .rst_i        (sys_rst),
    .enable_i     (enable),
    .cnt_step_o   (cnt_step),
    .pos_o        (pos),
    .frame_end_o  (frame_end),
    .frame_tick_o (frame_tick),
    .cycle_done_o (cycle_done)
  );

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    localparam int unsigned ChOff = k * OFFSET;

    logic [AddW-1:0] pos_sum, pos_k, lvl_k;
    logic            ch_on, led_d, led_q;
    mode_e           mode_d, mode_q;

    always_comb begin
      pos_sum = AddW'(pos) + AddW'(ChOff);
      pos_k   = (pos_sum >= AddW'(PERIOD)) ? pos_sum - AddW'(PERIOD) : pos_sum;
      // Triangle: rising half copies pos_k, falling half mirrors it.
      lvl_k   = (pos_k <= AddW'(CNT_STEP_MAX)) ? pos_k : AddW'(PERIOD - 1) - pos_k;
      ch_on   = 1'b0;
      unique case (mode_q)
        MODE_OFF:    ch_on = 1'b0;
        MODE_ON:     ch_on = 1'b1;
        MODE_BREATH: ch_on = (AddW'(cnt_step) < lvl_k);
        MODE_BLINK:  ch_on = (pos_k <= AddW'(CNT_STEP_MAX));
      endcase
      led_d  = (enable && ch_on) ? LED_ON_LVL : ~LED_ON_LVL;
      mode_d = frame_end ? mode_e'(mode[2*k +: 2]) : mode_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        mode_q <= MODE_OFF;
        led_q  <= ~LED_ON_LVL;
      end else begin
        mode_q <= mode_d;
        led_q  <= led_d;
      end
    end

    assign led_out[k] = led_q;
  end

endmodule

// File: tb/tb_breath_led_multi.sv
// Scoreboard bench for breath_led_multi: per-frame low-time windows and tick timing are
// queued by the stimulus and checked by an independent monitor at each frame_tick.
module tb_breath_led_multi;

  logic       sys_clk;
  logic       sys_rst;
  logic       enable;
  logic [7:0] mode;
  logic [3:0] led_out;
  logic       frame_tick;
  logic       cycle_done;

  breath_led_multi #(
    .CH_NUM       (4),
    .CNT_1US_MAX  (4),
    .CNT_STEP_MAX (9),
    .LED_ON_LVL   (1'b0),
    .PHASE_EN     (1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .mode       (mode),
    .led_out    (led_out),
    .frame_tick (frame_tick),
    .cycle_done (cycle_done)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    int pos;
    int len;
    bit cd;
    int low0;
    int low1;
    int low2;
    int low3;
  } win_t;

  win_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Hand-written breath triangle for PERIOD=20 frames, 10 steps per frame.
  int lvl_tab[20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

  // Expected lit (low) cycles in one 50-cycle frame for channel k.
  function automatic int exp_low(int p, int k, logic [7:0] m);
    int pk;
    logic [1:0] mk;
    pk = (p + 5 * k) % 20;
    mk = m[2*k +: 2];
    case (mk)
      2'b00:   return 0;
      2'b01:   return 50;
      2'b10:   return lvl_tab[pk] * 5;
      default: return (pk <= 9) ? 50 : 0;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic en_seen = 1'b1;
  initial forever begin
    @(posedge sys_clk);
    en_seen = enable;
  end

  initial begin
    int   c0, c1, c2, c3, len;
    win_t e;
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; len = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst || !en_seen) begin
        vectors++;
        if (led_out !== 4'hF || frame_tick !== 1'b0 || cycle_done !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_outputs t=%0t: got led=%h tick=%b cd=%b, required led=f tick=0 cd=0",
                   $time, led_out, frame_tick, cycle_done);
        end
      end
      if (sys_rst || !enable) begin
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; len = 0;
      end else begin
        len++;
        if (led_out[0] === 1'b0) c0++;
        if (led_out[1] === 1'b0) c1++;
        if (led_out[2] === 1'b0) c2++;
        if (led_out[3] === 1'b0) c3++;
        if (frame_tick === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_tick t=%0t: got frame_tick=1, required no tick", $time);
          end else begin
            e = exp_q.pop_front();
            if (c0 != e.low0 || c1 != e.low1 || c2 != e.low2 || c3 != e.low3 ||
                len != e.len || cycle_done !== e.cd) begin
              miscompares++;
              $display({"FAIL frame pos=%0d: got low=%0d/%0d/%0d/%0d len=%0d cd=%b, ",
                        "required low=%0d/%0d/%0d/%0d len=%0d cd=%b"},
                       e.pos, c0, c1, c2, c3, len, cycle_done,
                       e.low0, e.low1, e.low2, e.low3, e.len, e.cd);
            end
          end
          c0 = 0; c1 = 0; c2 = 0; c3 = 0; len = 0;
        end else if (cycle_done === 1'b1) begin
          vectors++;
          miscompares++;
          $display("FAIL lone_cycle_done t=%0t: got cd=1 without tick, required cd=0", $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int         pos_s;
  logic [7:0] shadow_s;
  bit         first_s;

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_mode(input logic [7:0] m);
    @(posedge sys_clk);
    #1 mode = m;
  endtask

  task automatic push_frame();
    win_t w;
    w.pos  = pos_s;
    w.cd   = (pos_s == 19);
    // First window after reset/enable includes the cycle before the first counting edge.
    w.len  = first_s ? 51 : 50;
    w.low0 = exp_low(pos_s, 0, shadow_s);
    w.low1 = exp_low(pos_s, 1, shadow_s);
    w.low2 = exp_low(pos_s, 2, shadow_s);
    w.low3 = exp_low(pos_s, 3, shadow_s);
    exp_q.push_back(w);
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 120 && !seen; c++) begin
      @(negedge sys_clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout pos=%0d: got no frame_tick in 120 cycles, required one", pos_s);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      push_frame();
      wait_tick();
      pos_s    = (pos_s + 1) % 20;
      shadow_s = mode;
      first_s  = 1'b0;
    end
  endtask

  initial begin
    sys_rst  = 1'b1;
    enable   = 1'b1;
    mode     = 8'hAA;
    pos_s    = 0;
    shadow_s = 8'h00;
    first_s  = 1'b1;
    cycles(3);
    sys_rst = 1'b0;
    frames(3);

    // Reset mid-frame: partial frame is discarded, timing restarts.
    cycles(7);
    sys_rst = 1'b1;
    cycles(3);
    sys_rst  = 1'b0;
    pos_s    = 0;
    shadow_s = 8'h00;
    first_s  = 1'b1;
    // Full breath cycle (cycle_done on the 20th window) plus pos=0 stagger frame.
    frames(21);

    // ch2 breath -> on mid-frame; takes effect from the next frame.
    set_mode(8'h9A);
    frames(3);

    // ch0/ch3 blink, ch1 off, ch2 on.
    set_mode(8'hD3);
    frames(21);

    while (pos_s != 7) frames(1);
    cycles(10);
    enable = 1'b0;
    cycles(120);
    enable  = 1'b1;
    pos_s   = 0;
    first_s = 1'b1;
    frames(2);

    cycles(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_windows: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/breath_led_multi.md
Name: breath_led_multi

Overview:
Multi-channel breathing-LED driver and parametrised successor to the single-channel breath LED. One shared timebase (1 us prescaler, then PWM step counter, then breath position counter) drives CH_NUM independent PWM outputs. Each channel has its own mode (off / on / breath / blink) and a fixed phase stagger, so the channels breathe in a rolling wave. It sits between the board clock/reset and the LED pins.

Parameters:
CH_NUM, 4, number of LED channels (1..16)
CNT_1US_MAX, 49, prescaler terminal count (sys_clk cycles per us minus 1; 49 at 50 MHz)
CNT_STEP_MAX, 999, PWM steps per frame minus 1; also frames per half-breath minus 1
LED_ON_LVL, 1'b0, pin level that lights the LED (board LEDs are active-low)
PHASE_EN, 1, 1 = stagger channels, 0 = all channels in phase

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  asynchronous, active-high reset
enable  input  1  1 = run timebase; 0 = freeze counters at 0 and force LEDs off
mode  input  2*CH_NUM  per-channel mode, channel k at bits [2k+1:2k]: 00 off, 01 on, 10 breath, 11 blink
led_out  output  CH_NUM  LED pin drive, bit k = channel k
frame_tick  output  1  one-cycle pulse at each frame end (PWM step counter wrap)
cycle_done  output  1  one-cycle pulse when the breath position wraps from PERIOD-1 to 0

Behaviour:
- Derived constants: PERIOD = 2*(CNT_STEP_MAX+1) frames; OFFSET = PERIOD/CH_NUM (integer division) when PHASE_EN=1, else 0.
- Reset (sys_rst high, asynchronous): cnt_us, cnt_step, pos, and the mode shadow registers = 0; led_out = all ~LED_ON_LVL; frame_tick = cycle_done = 0. Counting resumes on the first sys_clk edge after sys_rst deasserts.
- cnt_us: counts 0..CNT_1US_MAX when enable=1 and wraps to 0. us_tick = (cnt_us == CNT_1US_MAX).
- cnt_step: advances on us_tick over 0..CNT_STEP_MAX. frame_end = us_tick && cnt_step == CNT_STEP_MAX.
- pos: advances on frame_end over 0..PERIOD-1 and wraps to 0.
- frame_tick is the registered frame_end. cycle_done is the registered (frame_end && pos == PERIOD-1). Both assert in the cycle after the wrap and last exactly one cycle.
- Channel k position: pos_k = (pos + k*OFFSET) mod PERIOD. Compute it with one conditional subtract; k*OFFSET < PERIOD by construction.
- Level: lvl_k = pos_k when pos_k <= CNT_STEP_MAX, else PERIOD-1-pos_k. Range 0..CNT_STEP_MAX, so duty = lvl_k/(CNT_STEP_MAX+1).
- Mode shadowing: mode[2k+1:2k] is copied into the shadow register only on frame_end. A mode change therefore takes effect at the next frame boundary and never truncates a PWM period.
- Channel on-condition by shadowed mode:
  - off: never on.
  - on: always on.
  - breath: on while cnt_step < lvl_k.
  - blink: on while pos_k <= CNT_STEP_MAX.
- led_out[k] is registered: LED_ON_LVL when the on-condition holds, else ~LED_ON_LVL. Latency is 1 cycle from the counter state to the pin.
- Breath boundary values: lvl_k = 0 gives fully dark for the whole frame (no 1-step glitch). Peak lvl_k = CNT_STEP_MAX gives on for CNT_STEP_MAX of CNT_STEP_MAX+1 steps; the peak is held for two consecutive frames (pos_k = CNT_STEP_MAX and CNT_STEP_MAX+1).
- enable=0: all counters cleared synchronously to 0; led_out = all off regardless of mode; no ticks; shadow modes hold. On re-enable, counting restarts from pos=0.
- Reset mid-frame: all state returns to reset values immediately, with no pending tick afterwards.
- Widths: every counter width is $clog2(max+1); the pos arithmetic uses $clog2(2*PERIOD) bits to avoid overflow in the add.

Decomposition:
- Package breath_pkg holds:
  - the mode encodings MODE_OFF, MODE_ON, MODE_BREATH, MODE_BLINK;
  - the 2-bit mode typedef;
  - a width helper function.
- Sub-module breath_timebase holds cnt_us, cnt_step, pos, frame_end and cycle wrap, and is shared by all channels.
- The per-channel level/compare logic is a generate loop in the top.

Test Plan:
(Bench parameters: CNT_1US_MAX=4, CNT_STEP_MAX=9, CH_NUM=4, LED_ON_LVL=0, PHASE_EN=1. This gives a 50-cycle frame, PERIOD=20 frames, OFFSET=5 and a 1000-cycle breath.)
- Reset/idle: assert sys_rst mid-run for 3 cycles, then release. Required: led_out=4'hF during reset; first frame_tick 51 cycles after release (frame_end on cycle 50, pulse registered one cycle later); first cycle_done at 1001.
- Breath duty: all channels in breath mode (mode=8'hAA). For ch0 in frame pos=3, required: low for exactly 3 us (15 cycles), then high for 35 cycles. In frames pos=9 and pos=10, required: low for 45 cycles. In frame pos=0, required: never low.
- Phase stagger: mode=8'hAA, sample at pos=0. Required levels: ch1=5, ch2=9 (pos_k=10), ch3=4 (pos_k=15). Check the low-time per frame is 25, 45 and 20 cycles respectively.
- Mode switch: change ch2 from breath to on mid-frame. Required: ch2 unchanged until the next frame_end, then led_out[2]=0 continuously from the following cycle.
- Blink and off/on: mode=8'b11_01_00_11. Required: ch0 low for frames pos 0..9 and high for 10..19. ch3 follows the same pattern shifted by 15 frames. ch1 constant high; ch2 constant low.
- Enable drop: deassert enable at pos=7. Required: led_out=4'hF within 1 cycle, no frame_tick while low. After re-enable, the first frame_tick comes 51 cycles later with pos restarted at 0.
